// File: rtl/sram_weight_burst_if.sv
// Loader, burst-request and weight-stream signals of the weight SRAM burst engine.
// The PE array consumes the stream; the loader/controller drives writes and burst requests.
interface sram_weight_burst_if #(
  parameter int ADDR_BIT = 10,
  parameter int DATA_W   = 32,
  parameter int LANES    = 64,
  parameter int LEN_BIT  = 10
) ();
  localparam int BYTES = DATA_W / 8;

  logic [ADDR_BIT-1:0]      WADDR;
  logic                     WE;
  logic [BYTES-1:0]         BE;
  logic [DATA_W-1:0]        DI;
  logic                     start;
  logic [ADDR_BIT-1:0]      start_addr;
  logic [LEN_BIT-1:0]       len;
  logic [0:LANES-1][7:0]    DO;
  logic                     DO_valid;
  logic                     DO_ready;
  logic                     busy;
  logic                     done;

  modport slave (
    input  WADDR, WE, BE, DI, start, start_addr, len, DO_ready,
    output DO, DO_valid, busy, done
  );

  modport master (
    output WADDR, WE, BE, DI, start, start_addr, len, DO_ready,
    input  DO, DO_valid, busy, done
  );
endinterface

// File: rtl/sram_weight_burst.sv
// Byte-writable weight SRAM with a start/len burst engine that streams transposed
// LANES-wide int8 vectors to the PE array over a valid/ready handshake.
module sram_weight_burst #(
  parameter int ADDR_BIT = 10,
  parameter int DATA_W   = 32,
  parameter int LANES    = 64,
  parameter int GRP      = 8,
  parameter int STRIDE   = 16,
  parameter int TILE     = 128,
  parameter int LEN_BIT  = 10
) (
  input logic               CLK,
  input logic               RST,
  sram_weight_burst_if.slave bus
);
  localparam int BYTES = DATA_W / 8;
  localparam int LB    = $clog2(BYTES);
  localparam int DEPTH = 2 ** ADDR_BIT;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                  state_r;
  logic [BYTES-1:0][7:0]   ram_r [DEPTH];
  logic [ADDR_BIT-1:0]     rd_addr_r;
  logic [LEN_BIT-1:0]      remaining_r;
  logic [0:LANES-1][7:0]   do_r;
  logic                    do_valid_r;
  logic                    busy_r;
  logic                    done_r;

  logic [0:LANES-1][7:0]   beat_s;
  logic [LB-1:0]           plane_s;
  logic                    half_s;
  logic [ADDR_BIT-LB-2:0]  tile_s;
  logic [ADDR_BIT-1:0]     base_s;
  logic                    load_s;
  logic                    accept_s;

  // Word offset of lane j inside its tile half: row j%GRP is STRIDE words apart, column j/GRP adjacent.
  function automatic logic [ADDR_BIT-1:0] lane_off(input int j);
    return ADDR_BIT'((j % GRP) * STRIDE + j / GRP);
  endfunction

  assign plane_s  = rd_addr_r[LB-1:0];
  assign half_s   = rd_addr_r[LB];
  assign tile_s   = rd_addr_r[ADDR_BIT-1:LB+1];
  assign base_s   = ADDR_BIT'(int'(tile_s) * TILE + int'(half_s) * GRP);
  assign accept_s = do_valid_r && bus.DO_ready;
  assign load_s   = (state_r == READ) && (!do_valid_r || bus.DO_ready);

  // Byte-enabled loader writes, accepted in every state.
  always_ff @(posedge CLK) begin
    if (bus.WE) begin
      for (int b = 0; b < BYTES; b++) begin
        if (bus.BE[b]) begin
          ram_r[bus.WADDR][b] <= bus.DI[8*b +: 8];
        end
      end
    end
  end

  // Gather one transposed vector; the address wraps naturally in ADDR_BIT bits.
  always_comb begin
    beat_s = '0;
    for (int j = 0; j < LANES; j++) begin
      beat_s[j] = ram_r[base_s + lane_off(j)][plane_s];
    end
  end

  // Burst FSM; DO is registered from the pre-write RAM image, which gives read-first collisions.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= IDLE;
      rd_addr_r   <= '0;
      remaining_r <= '0;
      do_r        <= '0;
      do_valid_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            if (bus.len != LEN_BIT'(0)) begin
              rd_addr_r   <= bus.start_addr;
              remaining_r <= bus.len;
              busy_r      <= 1'b1;
              state_r     <= READ;
            end else begin
              done_r <= 1'b1;
            end
          end
        end
        READ: begin
          if (load_s) begin
            do_r        <= beat_s;
            do_valid_r  <= 1'b1;
            rd_addr_r   <= rd_addr_r + ADDR_BIT'(1);
            remaining_r <= remaining_r - LEN_BIT'(1);
            if (remaining_r == LEN_BIT'(1)) begin
              state_r <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (accept_s) begin
            do_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b1;
            state_r    <= IDLE;
          end
        end
        default: begin
          do_valid_r <= 1'b0;
          busy_r     <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  assign bus.DO       = do_r;
  assign bus.DO_valid = do_valid_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
endmodule

// File: tb/tb_sram_weight_burst.sv
// Randomised bench for sram_weight_burst against a flat-array model of the transposed read.
module tb_sram_weight_burst;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_weight_burst_if bus ();
  sram_weight_burst dut (.CLK(clk), .RST(rst), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] mem [1024];

  task automatic check_eq(input string tag, input logic [519:0] obs, input logic [519:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Expected vector straight from the address decomposition rule.
  function automatic logic [0:63][7:0] model_beat(input int a);
    logic [0:63][7:0] r;
    int p, h, t, w;
    p = a % 4;
    h = (a / 4) % 2;
    t = a / 8;
    for (int j = 0; j < 64; j++) begin
      w = (t * 128 + h * 8 + (j % 8) * 16 + j / 8) % 1024;
      r[j] = mem[w][8*p +: 8];
    end
    return r;
  endfunction

  task automatic write_word(input int a, input logic [3:0] be, input logic [31:0] di);
    bus.WADDR = 10'(a);
    bus.BE    = be;
    bus.DI    = di;
    bus.WE    = 1'b1;
    @(posedge clk); #1;
    bus.WE    = 1'b0;
    for (int b = 0; b < 4; b++) if (be[b]) mem[a][8*b +: 8] = di[8*b +: 8];
  endtask

  // mode 0: ready high, 1: ready 1,0,0 repeating, 2: random ready
  task automatic run_burst(input int sa, input int n, input int mode, output logic [0:63][7:0] last);
    logic [0:63][7:0] exp_q [$];
    logic [0:63][7:0] held;
    bit holding = 0, finished = 0, seen_valid = 0, busy_bad = 0, done_early = 0;
    int got = 0, cyc = 0;
    logic r;
    last = '0;
    for (int i = 0; i < n; i++) exp_q.push_back(model_beat((sa + i) % 1024));
    bus.start_addr = 10'(sa);
    bus.len        = 10'(n);
    bus.start      = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (cyc < 400) begin
      if (finished) begin
        check_eq("done_pulse", 520'(bus.done), 520'(1'b1));
        check_eq("valid_drop", 520'(bus.DO_valid), 520'(1'b0));
        check_eq("busy_drop", 520'(bus.busy), 520'(1'b0));
        @(posedge clk); #1;
        check_eq("done_single", 520'(bus.done), 520'(1'b0));
        break;
      end
      if (bus.done) done_early = 1;
      if (!bus.busy) busy_bad = 1;
      if (holding) begin
        check_eq("stall_hold", {bus.DO_valid, bus.DO}, {1'b1, held});
        holding = 0;
      end
      if (bus.DO_valid && !seen_valid) begin
        seen_valid = 1;
        check_eq("latency", 520'(cyc), 520'(1));
      end
      case (mode)
        0: r = 1'b1;
        1: r = (cyc % 3 == 0);
        default: r = ($urandom_range(0, 3) != 0);
      endcase
      bus.DO_ready = r;
      if (bus.DO_valid && r) begin
        if (got < n) check_eq($sformatf("beat%0d_a%0d", got, (sa + got) % 1024), bus.DO, exp_q[got]);
        last = bus.DO;
        got++;
        if (got == n) finished = 1;
      end else if (bus.DO_valid) begin
        held = bus.DO;
        holding = 1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("beat_count", 520'(got), 520'(n));
    check_eq("busy_during", 520'(busy_bad), 520'(1'b0));
    check_eq("no_early_done", 520'(done_early), 520'(1'b0));
    bus.DO_ready = 1'b0;
  endtask

  initial begin
    logic [0:63][7:0] last;
    logic [0:63][7:0] exp_old;
    bit bad;
    bus.WADDR = '0; bus.WE = 1'b0; bus.BE = '0; bus.DI = '0;
    bus.start = 1'b0; bus.start_addr = '0; bus.len = '0; bus.DO_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", 520'(bus.DO_valid), 520'(1'b0));
    check_eq("rst_busy", 520'(bus.busy), 520'(1'b0));
    check_eq("rst_done", 520'(bus.done), 520'(1'b0));
    check_eq("rst_do", 520'(bus.DO), 520'(0));
    rst = 1'b0;

    for (int k = 0; k < 1024; k++)
      write_word(k, 4'hF, (k < 256) ? 32'(k) * 32'h01010101 : 32'($urandom));

    // Test 1: identity-like pattern, four identical beats
    run_burst(0, 4, 0, last);
    check_eq("t1_lane9", 520'(last[9]), 520'(8'h11));

    // Test 2: single byte-plane write
    write_word(0, 4'b0100, 32'hAABBCCDD);
    run_burst(2, 1, 0, last);
    check_eq("t2_lane0", 520'(last[0]), 520'(8'hBB));

    // Test 3: backpressure pattern
    run_burst($urandom_range(0, 1023), 8, 1, last);

    // Test 4: address wrap
    run_burst(1022, 4, 0, last);

    // Test 5: write to word 16 on the load edge of its beat
    bus.start_addr = 10'd0; bus.len = 10'd1; bus.start = 1'b1; bus.DO_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    exp_old = model_beat(0);
    bus.WADDR = 10'd16; bus.BE = 4'hF; bus.DI = 32'hFFFFFFFF; bus.WE = 1'b1;
    @(posedge clk); #1;
    bus.WE = 1'b0;
    mem[16] = 32'hFFFFFFFF;
    check_eq("t5_valid", 520'(bus.DO_valid), 520'(1'b1));
    check_eq("t5_old_beat", 520'(bus.DO), 520'(exp_old));
    check_eq("t5_old_lane1", 520'(bus.DO[1]), 520'(8'h10));
    @(posedge clk); #1;
    check_eq("t5_done", 520'(bus.done), 520'(1'b1));
    bus.DO_ready = 1'b0;
    @(posedge clk); #1;
    run_burst(0, 1, 0, last);
    check_eq("t5_new_lane1", 520'(last[1]), 520'(8'hFF));

    // Random writes interleaved with random bursts under random backpressure
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(1, 6))
        write_word($urandom_range(0, 1023), 4'($urandom), $urandom);
      run_burst($urandom_range(0, 1023), $urandom_range(1, 12), 2, last);
    end

    // Test 6: reset mid-burst
    bus.start_addr = 10'($urandom_range(0, 1023)); bus.len = 10'd6; bus.start = 1'b1;
    bus.DO_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("t6_valid", 520'(bus.DO_valid), 520'(1'b0));
    check_eq("t6_busy", 520'(bus.busy), 520'(1'b0));
    check_eq("t6_do", 520'(bus.DO), 520'(0));
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.done || bus.DO_valid) bad = 1;
      @(posedge clk); #1;
    end
    check_eq("t6_quiet", 520'(bad), 520'(1'b0));

    // len=0 request: done only
    bus.len = 10'd0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check_eq("len0_done", 520'(bus.done), 520'(1'b1));
    check_eq("len0_valid", 520'(bus.DO_valid), 520'(1'b0));
    check_eq("len0_busy", 520'(bus.busy), 520'(1'b0));
    @(posedge clk); #1;
    check_eq("len0_done_end", 520'(bus.done), 520'(1'b0));
    check_eq("len0_valid_end", 520'(bus.DO_valid), 520'(1'b0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
